// File: rtl/awgn_link_array.sv
// N_CH-channel BPSK link: sign-bit mapper, LFSR pseudo-Gaussian noise with runtime gain,
// hard-decision slicer and saturating per-channel bit-error counters.
module awgn_link_array #(
  parameter int                  N_CH  = 4,
  parameter int                  W     = 16,
  parameter logic signed [W-1:0] AMP   = 16'sd1024,
  parameter logic [31:0]         SEED  = 32'hACE1_0001,
  parameter int                  CNT_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  noise_off,
  input  logic [2:0]            noise_scale,
  input  logic                  in_valid,
  input  logic [N_CH*W-1:0]     in_data,
  output logic                  out_valid,
  output logic [N_CH*W-1:0]     out_data,
  input  logic                  clr_cnt,
  output logic [N_CH*CNT_W-1:0] err_cnt
);

  localparam int                   NW      = W + 8;
  localparam logic [31:0]          POLY    = 32'h8020_0003;
  localparam logic [W-1:0]         SYM_POS = W'(1);
  localparam logic [W-1:0]         SYM_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [NW-1:0] SAT_HI  = {{(NW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [NW-1:0] SAT_LO  = {{(NW-W+1){1'b1}}, {(W-1){1'b0}}};

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Sum of the four signed bytes approximates a Gaussian (central limit).
  function automatic logic signed [9:0] noise_raw(input logic [31:0] s);
    return $signed({{2{s[7]}},  s[7:0]})   + $signed({{2{s[15]}}, s[15:8]})
         + $signed({{2{s[23]}}, s[23:16]}) + $signed({{2{s[31]}}, s[31:24]});
  endfunction

  function automatic logic signed [NW-1:0] scaled_noise(input logic signed [9:0] raw,
                                                        input logic [2:0] sh);
    logic signed [NW-1:0] ext;
    ext = {{(NW-10){raw[9]}}, raw};
    return ext <<< sh;
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [NW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[W-1:0];
    else if (v < SAT_LO) return SAT_LO[W-1:0];
    else                 return v[W-1:0];
  endfunction

  // Magnitude bits carry no information for BPSK; only the sign bits are used.
  logic unused_mag;
  assign unused_mag = ^in_data;

  // ---- Stage 1: map sign bit to +/-AMP, capture this symbol's raw noise ----
  logic                vld_p1;
  logic [31:0]         lfsr   [N_CH];
  logic [N_CH-1:0]     b_p1;
  logic signed [W-1:0] x_p1   [N_CH];
  logic signed [9:0]   raw_p1 [N_CH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < N_CH; k++) lfsr[k] <= SEED ^ 32'(k);
    end else begin
      vld_p1 <= in_valid;
      if (in_valid)
        for (int k = 0; k < N_CH; k++) lfsr[k] <= lfsr_next(lfsr[k]);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      b_p1[k]   <= in_data[k*W+W-1];
      x_p1[k]   <= in_data[k*W+W-1] ? -AMP : AMP;
      raw_p1[k] <= noise_raw(lfsr[k]);
    end
  end

  // ---- Stage 2: add scaled noise, saturate to W bits ----
  logic signed [NW-1:0] n_w   [N_CH];
  logic signed [NW-1:0] x_w   [N_CH];
  logic signed [W-1:0]  r_nxt [N_CH];

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      n_w[k]   = noise_off ? '0 : scaled_noise(raw_p1[k], noise_scale);
      x_w[k]   = {{(NW-W){x_p1[k][W-1]}}, x_p1[k]};
      r_nxt[k] = sat_w(x_w[k] + n_w[k]);
    end
  end

  logic                vld_p2;
  logic [N_CH-1:0]     b_p2;
  logic signed [W-1:0] r_p2 [N_CH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    b_p2 <= b_p1;
    for (int k = 0; k < N_CH; k++) r_p2[k] <= r_nxt[k];
  end

  // ---- Stage 3: hard decision and error counting ----
  logic [N_CH-1:0]  err_p2;
  logic [CNT_W-1:0] cnt [N_CH];

  always_comb begin
    err_p2 = '0;
    for (int k = 0; k < N_CH; k++) err_p2[k] = r_p2[k][W-1] ^ b_p2[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
    end else begin
      out_valid <= vld_p2;
      for (int k = 0; k < N_CH; k++) begin
        if (vld_p2) out_data[k*W +: W] <= r_p2[k][W-1] ? SYM_NEG : SYM_POS;
        // Clear beats a same-cycle increment; counters stick at all-ones.
        if (clr_cnt)
          cnt[k] <= '0;
        else if (vld_p2 && err_p2[k] && (cnt[k] != {CNT_W{1'b1}}))
          cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    err_cnt = '0;
    for (int k = 0; k < N_CH; k++) err_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end

endmodule
